// File: rtl/outstanding_id_table.sv
// Reference-counted table of outstanding transaction IDs with per-ID origin tracking.
// Valid entries stay packed at the low indices; a freed entry is closed up by shifting the rest down.
module outstanding_id_table #(
    parameter int NUMBER_OF_PORTS   = 2,
    parameter int ID_WIDTH          = 16,
    parameter int NUMBER_OF_ENTRIES = 32,
    parameter int COUNT_WIDTH       = 4,
    localparam int ORIGIN_W = ($clog2(NUMBER_OF_PORTS) > 1) ? $clog2(NUMBER_OF_PORTS) : 1,
    localparam int OCC_W    = $clog2(NUMBER_OF_ENTRIES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ins_valid,
    output logic                   ins_ready,
    input  logic [ID_WIDTH-1:0]    ins_id,
    input  logic [ORIGIN_W-1:0]    ins_origin,
    output logic                   ins_conflict,
    input  logic                   rel_valid,
    input  logic [ID_WIDTH-1:0]    rel_id,
    output logic                   rel_error,
    input  logic                   lk_valid,
    input  logic [ID_WIDTH-1:0]    lk_id,
    output logic                   lk_resp_valid,
    output logic                   lk_hit,
    output logic [ORIGIN_W-1:0]    lk_origin,
    output logic [COUNT_WIDTH-1:0] lk_count,
    output logic [OCC_W-1:0]       occupancy,
    output logic                   full,
    output logic                   empty
);
    localparam int IDX_W = $clog2(NUMBER_OF_ENTRIES);
    localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

    typedef struct packed {
        logic                   valid;
        logic [ID_WIDTH-1:0]    id;
        logic [ORIGIN_W-1:0]    origin;
        logic [COUNT_WIDTH-1:0] count;
    } entry_t;

    entry_t           table_q [NUMBER_OF_ENTRIES];
    entry_t           table_d [NUMBER_OF_ENTRIES];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             full_q, empty_q;

    logic             ins_hit, rel_hit, lk_match;
    logic [IDX_W-1:0] ins_idx, rel_idx, lk_idx;
    entry_t           ins_entry, rel_entry;
    logic             ins_fire, ins_same_origin, cancel;
    logic             do_inc, do_dec, do_remove, do_append, do_conflict, rel_miss;
    int               append_idx;

    always_comb begin
        ins_hit  = 1'b0;
        ins_idx  = '0;
        rel_hit  = 1'b0;
        rel_idx  = '0;
        lk_match = 1'b0;
        lk_idx   = '0;
        for (int i = 0; i < NUMBER_OF_ENTRIES; i++) begin
            if (table_q[i].valid && table_q[i].id == ins_id) begin
                ins_hit = 1'b1;
                ins_idx = IDX_W'(i);
            end
            if (table_q[i].valid && table_q[i].id == rel_id) begin
                rel_hit = 1'b1;
                rel_idx = IDX_W'(i);
            end
            if (table_q[i].valid && table_q[i].id == lk_id) begin
                lk_match = 1'b1;
                lk_idx   = IDX_W'(i);
            end
        end
    end

    assign ins_entry = table_q[ins_idx];
    assign rel_entry = table_q[rel_idx];

    assign ins_ready       = ins_hit ? (ins_entry.count != CMAX) : !full_q;
    assign ins_fire        = ins_valid && ins_ready;
    assign ins_same_origin = (ins_entry.origin == ins_origin);

    // An increment and a release of the same entry in one cycle cancel each other out.
    assign cancel      = ins_fire && ins_hit && ins_same_origin && rel_valid && rel_hit
                         && (ins_idx == rel_idx);
    assign do_inc      = ins_fire && ins_hit && ins_same_origin && !cancel;
    assign do_conflict = ins_fire && ins_hit && !ins_same_origin;
    assign do_append   = ins_fire && !ins_hit;
    assign do_dec      = rel_valid && rel_hit && !cancel && (rel_entry.count != COUNT_WIDTH'(1));
    assign do_remove   = rel_valid && rel_hit && !cancel && (rel_entry.count == COUNT_WIDTH'(1));
    assign rel_miss    = rel_valid && !rel_hit;

    assign append_idx = int'(occ_q) - int'(do_remove);
    assign occ_d      = occ_q + OCC_W'(do_append) - OCC_W'(do_remove);

    // Count updates first, then compaction, then append at the post-compaction top.
    always_comb begin
        table_d = table_q;
        if (do_inc)
            table_d[ins_idx].count = table_q[ins_idx].count + 1'b1;
        if (do_dec)
            table_d[rel_idx].count = table_q[rel_idx].count - 1'b1;
        if (do_remove) begin
            for (int i = 0; i < NUMBER_OF_ENTRIES - 1; i++)
                if (i >= int'(rel_idx))
                    table_d[i] = table_d[i+1];
            table_d[NUMBER_OF_ENTRIES-1] = '0;
        end
        if (do_append) begin
            for (int i = 0; i < NUMBER_OF_ENTRIES; i++)
                if (i == append_idx)
                    table_d[i] = '{valid: 1'b1, id: ins_id, origin: ins_origin,
                                   count: COUNT_WIDTH'(1)};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUMBER_OF_ENTRIES; i++)
                table_q[i] <= '0;
            occ_q         <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            ins_conflict  <= 1'b0;
            rel_error     <= 1'b0;
            lk_resp_valid <= 1'b0;
            lk_hit        <= 1'b0;
            lk_origin     <= '0;
            lk_count      <= '0;
        end else begin
            table_q       <= table_d;
            occ_q         <= occ_d;
            full_q        <= (occ_d == OCC_W'(NUMBER_OF_ENTRIES));
            empty_q       <= (occ_d == '0);
            ins_conflict  <= do_conflict;
            rel_error     <= rel_miss;
            lk_resp_valid <= lk_valid;
            // Lookup sees the table as it was before this cycle's updates.
            if (lk_valid) begin
                lk_hit    <= lk_match;
                lk_origin <= lk_match ? table_q[lk_idx].origin : '0;
                lk_count  <= lk_match ? table_q[lk_idx].count : '0;
            end
        end
    end

    assign occupancy = occ_q;
    assign full      = full_q;
    assign empty     = empty_q;
endmodule

// File: tb/tb_outstanding_id_table.sv
// Bench for outstanding_id_table: hand vectors, directed corner sequences, and random traffic
// checked against a queue-based reference model.
module tb_outstanding_id_table;
    localparam int NE   = 32;
    localparam int CMAX = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        ins_valid, ins_ready, ins_conflict;
    logic [15:0] ins_id;
    logic [0:0]  ins_origin;
    logic        rel_valid, rel_error;
    logic [15:0] rel_id;
    logic        lk_valid, lk_resp_valid, lk_hit;
    logic [15:0] lk_id;
    logic [0:0]  lk_origin;
    logic [3:0]  lk_count;
    logic [5:0]  occupancy;
    logic        full, empty;

    always #5 clock = ~clock;

    outstanding_id_table dut (
        .clock(clock), .reset(reset),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_id(ins_id),
        .ins_origin(ins_origin), .ins_conflict(ins_conflict),
        .rel_valid(rel_valid), .rel_id(rel_id), .rel_error(rel_error),
        .lk_valid(lk_valid), .lk_id(lk_id), .lk_resp_valid(lk_resp_valid),
        .lk_hit(lk_hit), .lk_origin(lk_origin), .lk_count(lk_count),
        .occupancy(occupancy), .full(full), .empty(empty)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: entries kept in insertion order.
    int   q_id[$];
    int   q_org[$];
    int   q_cnt[$];
    logic m_hit;
    int   m_org, m_cnt;
    logic rdy_seen;

    typedef struct {
        int iv, iid, iorg, rv, rid, lv, lid;
        int e_rdy, e_hit, e_org, e_cnt, e_occ, e_conf, e_err;
    } vec_t;
    vec_t vecs[13];

    function automatic int mfind(int id);
        foreach (q_id[i]) if (q_id[i] == id) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ins_valid = 0; ins_id = 0; ins_origin = 0;
        rel_valid = 0; rel_id = 0; lk_valid = 0; lk_id = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1;
        ins_valid = 1; ins_id = 16'h1234; rel_valid = 1; rel_id = 16'h4321;
        lk_valid = 1; lk_id = 16'h1234;
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        idle_inputs();
        q_id.delete(); q_org.delete(); q_cnt.delete();
        m_hit = 0; m_org = 0; m_cnt = 0;
        #1;
        chk("rst_occupancy", occupancy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_conflict", ins_conflict, 0);
        chk("rst_rel_error", rel_error, 0);
        chk("rst_lk_resp_valid", lk_resp_valid, 0);
        chk("rst_lk_hit", lk_hit, 0);
        chk("rst_lk_origin", lk_origin, 0);
        chk("rst_lk_count", lk_count, 0);
    endtask

    // One cycle of stimulus; model predicts everything from its own rules.
    task automatic step(input int iv, input int iid, input int iorg,
                        input int rv, input int rid, input int lv, input int lid);
        int ii, ri, li;
        bit m_ready, fire, conf, err;
        @(negedge clock);
        ins_valid = iv[0]; ins_id = iid[15:0]; ins_origin = iorg[0:0];
        rel_valid = rv[0]; rel_id = rid[15:0];
        lk_valid = lv[0]; lk_id = lid[15:0];
        ii = mfind(iid);
        ri = mfind(rid);
        m_ready = (ii >= 0) ? (q_cnt[ii] < CMAX) : (q_id.size() < NE);
        if (lv != 0) begin
            li = mfind(lid);
            m_hit = (li >= 0);
            m_org = (li >= 0) ? q_org[li] : 0;
            m_cnt = (li >= 0) ? q_cnt[li] : 0;
        end
        #1;
        rdy_seen = ins_ready;
        chk("ins_ready", ins_ready, m_ready);
        fire = (iv != 0) && m_ready;
        conf = 0;
        err  = 0;
        if (!(fire && rv != 0 && iid == rid && ii >= 0 && q_org[ii] == iorg)) begin
            if (fire && ii >= 0) begin
                if (q_org[ii] == iorg) q_cnt[ii]++;
                else conf = 1;
            end
            if (rv != 0) begin
                if (ri < 0) err = 1;
                else if (q_cnt[ri] > 1) q_cnt[ri]--;
                else begin
                    q_id.delete(ri); q_org.delete(ri); q_cnt.delete(ri);
                end
            end
            if (fire && ii < 0) begin
                q_id.push_back(iid); q_org.push_back(iorg); q_cnt.push_back(1);
            end
        end
        @(posedge clock);
        #1;
        idle_inputs();
        chk("lk_resp_valid", lk_resp_valid, lv[0]);
        chk("lk_hit", lk_hit, m_hit);
        chk("lk_origin", lk_origin, m_org);
        chk("lk_count", lk_count, m_cnt);
        chk("ins_conflict", ins_conflict, conf);
        chk("rel_error", rel_error, err);
        chk("occupancy", occupancy, q_id.size());
        chk("full", full, q_id.size() == NE);
        chk("empty", empty, q_id.size() == 0);
    endtask

    initial begin
        reset = 1;
        idle_inputs();

        //         iv iid    org rv rid    lv lid     rdy hit org cnt occ conf err
        vecs[0]  = '{1, 'h12, 1, 0, 0,     0, 0,      1,  0,  0,  0,  1,  0,  0};
        vecs[1]  = '{0, 0,    0, 0, 0,     1, 'h12,   1,  1,  1,  1,  1,  0,  0};
        vecs[2]  = '{0, 0,    0, 0, 0,     1, 'h0,    1,  0,  0,  0,  1,  0,  0};
        vecs[3]  = '{1, 'h3,  0, 0, 0,     0, 0,      1,  0,  0,  0,  2,  0,  0};
        vecs[4]  = '{1, 'h3,  1, 0, 0,     0, 0,      1,  0,  0,  0,  2,  1,  0};
        vecs[5]  = '{0, 0,    0, 0, 0,     1, 'h3,    1,  1,  0,  1,  2,  0,  0};
        vecs[6]  = '{1, 'h5,  0, 0, 0,     0, 0,      1,  0,  0,  0,  3,  0,  0};
        vecs[7]  = '{1, 'h5,  0, 0, 0,     0, 0,      1,  0,  0,  0,  3,  0,  0};
        vecs[8]  = '{1, 'h5,  0, 1, 'h5,   1, 'h5,    1,  1,  0,  2,  3,  0,  0};
        vecs[9]  = '{0, 0,    0, 0, 0,     1, 'h5,    1,  1,  0,  2,  3,  0,  0};
        vecs[10] = '{0, 0,    0, 1, 'h77,  0, 0,      1,  0,  0,  0,  3,  0,  1};
        vecs[11] = '{1, 'h77, 1, 1, 'h77,  0, 0,      1,  0,  0,  0,  4,  0,  1};
        vecs[12] = '{0, 0,    0, 0, 0,     1, 'h77,   1,  1,  1,  1,  4,  0,  0};

        do_reset();
        foreach (vecs[k]) begin
            step(vecs[k].iv, vecs[k].iid, vecs[k].iorg, vecs[k].rv, vecs[k].rid,
                 vecs[k].lv, vecs[k].lid);
            chk($sformatf("vec%0d_ready", k), rdy_seen, vecs[k].e_rdy);
            if (vecs[k].lv != 0) begin
                chk($sformatf("vec%0d_hit", k), lk_hit, vecs[k].e_hit);
                chk($sformatf("vec%0d_origin", k), lk_origin, vecs[k].e_org);
                chk($sformatf("vec%0d_count", k), lk_count, vecs[k].e_cnt);
            end
            chk($sformatf("vec%0d_occ", k), occupancy, vecs[k].e_occ);
            chk($sformatf("vec%0d_conflict", k), ins_conflict, vecs[k].e_conf);
            chk($sformatf("vec%0d_rel_error", k), rel_error, vecs[k].e_err);
        end

        // Counter saturation and drain.
        do_reset();
        for (int n = 0; n < CMAX; n++) step(1, 'hA0, 0, 0, 0, 0, 0);
        step(1, 'hA0, 0, 0, 0, 1, 'hA0);
        chk("sat_ready", rdy_seen, 0);
        chk("sat_count", lk_count, 15);
        for (int n = 0; n < CMAX; n++) step(0, 0, 0, 1, 'hA0, 0, 0);
        chk("drain_empty", empty, 1);
        step(0, 0, 0, 1, 'hA0, 0, 0);
        chk("drain_rel_error", rel_error, 1);

        // Fill, compaction, and full-table same-cycle insert/release.
        do_reset();
        for (int n = 0; n < NE; n++) step(1, n, n % 2, 0, 0, 0, 0);
        chk("fill_full", full, 1);
        step(1, 40, 0, 0, 0, 0, 0);
        chk("full_new_ready", rdy_seen, 0);
        step(1, 5, 1, 0, 0, 0, 0);
        chk("full_dup_ready", rdy_seen, 1);
        step(0, 0, 0, 1, 5, 0, 0);
        step(0, 0, 0, 1, 10, 0, 0);
        chk("compact_occ", occupancy, 31);
        for (int n = 0; n < NE; n++) step(0, 0, 0, 0, 0, 1, n);
        step(1, 10, 0, 0, 0, 0, 0);
        chk("refill_full", full, 1);
        step(1, 99, 0, 1, 7, 0, 0);
        chk("full_swap_ready", rdy_seen, 0);
        chk("full_swap_occ", occupancy, 31);
        step(0, 0, 0, 0, 0, 1, 99);
        chk("full_swap_miss", lk_hit, 0);
        step(1, 99, 1, 0, 0, 0, 0);
        chk("late_insert_full", full, 1);
        step(0, 0, 0, 0, 0, 1, 99);
        chk("late_insert_hit", lk_hit, 1);

        // Random traffic over a small ID pool so hits, fills and saturation all occur.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            step(($urandom_range(0, 99) < 60) ? 1 : 0, $urandom_range(0, 39), $urandom_range(0, 1),
                 ($urandom_range(0, 99) < 40) ? 1 : 0, $urandom_range(0, 39),
                 ($urandom_range(0, 99) < 50) ? 1 : 0, $urandom_range(0, 41));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/outstanding_id_table.md
Name: outstanding_id_table

Overview:
- Parametrised, reference-counted table of outstanding transaction IDs, instantiated once per scheduler bank in MemorEDF.
- Records which port (origin) issued each ID.
- Allows several outstanding transactions per ID.
- Answers origin lookups for returning responses, and compacts itself (shift-down) when an entry's count returns to zero.

Parameters:
- NUMBER_OF_PORTS, 2, number of requesting ports; ORIGIN_W = max(1, $clog2(NUMBER_OF_PORTS)).
- ID_WIDTH, 16, transaction ID width.
- NUMBER_OF_ENTRIES, 32, distinct IDs tracked; minimum 2. OCC_W = $clog2(NUMBER_OF_ENTRIES+1).
- COUNT_WIDTH, 4, per-entry outstanding counter width; maximum count CMAX = 2^COUNT_WIDTH-1.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ins_valid  in  1  insert request.
- ins_ready  out  1  insert accepted this cycle when ins_valid&ins_ready.
- ins_id  in  ID_WIDTH  ID to insert.
- ins_origin  in  ORIGIN_W  issuing port.
- ins_conflict  out  1  one-cycle pulse: insert dropped, ID present with a different origin.
- rel_valid  in  1  release (completion) request; always accepted.
- rel_id  in  ID_WIDTH  ID completing.
- rel_error  out  1  one-cycle pulse: released ID not present.
- lk_valid  in  1  lookup request.
- lk_id  in  ID_WIDTH  ID to look up.
- lk_resp_valid  out  1  lookup response, 1 cycle after lk_valid.
- lk_hit  out  1  ID was present.
- lk_origin  out  ORIGIN_W  origin of the matched entry; 0 on miss.
- lk_count  out  COUNT_WIDTH  outstanding count of the matched entry; 0 on miss.
- occupancy  out  OCC_W  number of valid entries.
- full  out  1  occupancy == NUMBER_OF_ENTRIES.
- empty  out  1  occupancy == 0.

Behaviour:
- Storage: per entry {valid, id, origin, count}. Valid entries are always packed in indices 0..occupancy-1, in insertion order. Invalid entries hold all-zero fields.
- Matching: an entry matches only if valid and its id equals the request ID. Invalid entries never match, including ID 0.
- Reset (synchronous, active-high): all entries cleared; occupancy=0; empty=1; full=0; ins_conflict, rel_error, lk_resp_valid, lk_hit, lk_origin, lk_count all 0.
- ins_ready (combinational) is 1 in two cases:
  - ins_id matches and that entry's count < CMAX;
  - ins_id does not match and the table is not full.
  - It does not depend on a release in the same cycle.
- Insert, on ins_valid&ins_ready:
  - matching entry with the same origin: count+1;
  - matching entry with a different origin: table unchanged, ins_conflict=1 next cycle;
  - no match: new entry {1, ins_id, ins_origin, count=1} appended at index occupancy; occupancy+1.
- Release, on rel_valid:
  - matching entry with count>1: count-1;
  - matching entry with count==1: entry removed; entries above it shift down one index; top slot zeroed; occupancy-1;
  - no match: rel_error=1 next cycle, nothing changed.
- Simultaneous insert and release, different IDs: both apply in the same cycle.
  - If the release frees an entry and the insert appends, the new entry lands at index occupancy-1 after compaction; occupancy unchanged.
- Simultaneous insert and release, same ID:
  - ID present: count unchanged, no removal.
  - ID absent: release flags rel_error; insert appends with count=1.
- Lookup: registered, latency 1. The response reflects table state before that cycle's insert/release. lk_valid=0 drives lk_resp_valid=0; the other lookup outputs hold their last value.
- occupancy/full/empty are registered and consistent with the table contents.
- All updates take effect at the next clock edge. A reset mid-operation discards all state and suppresses pending pulses.

Test Plan:
- Reset, insert 0x0012 origin 1, lookup 0x0012 -> next cycle lk_hit=1, lk_origin=1, lk_count=1, occupancy=1; lookup 0x0000 -> lk_hit=0.
- Insert ID 0x00A0 (origin 0) CMAX=15 times -> count=15, ins_ready=0 for 0x00A0. Release 15 times -> entry removed, empty=1. One more release -> rel_error pulse.
- Fill 32 distinct IDs 0..31 -> full=1, ins_ready=0 for ID 40 but 1 for ID 5. Release ID 10 -> IDs 11..31 shift to indices 10..30, occupancy=31.
- Table holds 0x3 origin 0; insert 0x3 origin 1 -> ins_conflict pulse, lk_count still 1.
- Full table; same cycle insert new ID 99 and release ID 7 (count 1) -> ins_ready=0, ID 99 not stored, occupancy=31. Next cycle insert 99 -> stored at index 31, full=1.
- Same cycle insert and release of present ID 0x5 (count 2) -> count 2; lookup issued that cycle returns lk_count=2.
